// File: rtl/pulse_pkg.sv
// Shared frame definitions for the parameter readback path: header byte, frame layout, FSM states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package pulse_pkg;

    // First byte of every readback frame
    localparam logic [7:0] HEADER      = 8'hA5;
    localparam int         FRAME_BYTES = 17;

    // Position of each field inside the 17-byte frame
    localparam logic [4:0] IDX_HDR     = 5'd0;
    localparam logic [4:0] IDX_PER3    = 5'd1;
    localparam logic [4:0] IDX_PER2    = 5'd2;
    localparam logic [4:0] IDX_PER1    = 5'd3;
    localparam logic [4:0] IDX_PER0    = 5'd4;
    localparam logic [4:0] IDX_P1W_HI  = 5'd5;
    localparam logic [4:0] IDX_P1W_LO  = 5'd6;
    localparam logic [4:0] IDX_DEL_HI  = 5'd7;
    localparam logic [4:0] IDX_DEL_LO  = 5'd8;
    localparam logic [4:0] IDX_P2W_HI  = 5'd9;
    localparam logic [4:0] IDX_P2W_LO  = 5'd10;
    localparam logic [4:0] IDX_NUTD_HI = 5'd11;
    localparam logic [4:0] IDX_NUTD_LO = 5'd12;
    localparam logic [4:0] IDX_NUTW    = 5'd13;
    localparam logic [4:0] IDX_ATT     = 5'd14;
    localparam logic [4:0] IDX_FLAGS   = 5'd15;
    localparam logic [4:0] IDX_CHK     = 5'd16;

    // Frame-level sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } frame_state_t;

    // Captured copy of the live pulse parameter set (113 bits)
    typedef struct packed {
        logic [31:0] per;
        logic [15:0] p1wid;
        logic [15:0] del;
        logic [15:0] p2wid;
        logic [15:0] nut_d;
        logic [7:0]  nut_w;
        logic [6:0]  pr_att;
        logic        cp;
        logic        bl;
    } snap_t;

    // Payload byte at frame position idx; header and checksum positions return 0
    function automatic logic [7:0] payload_byte(input snap_t s, input logic [4:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            IDX_PER3:    b = s.per[31:24];
            IDX_PER2:    b = s.per[23:16];
            IDX_PER1:    b = s.per[15:8];
            IDX_PER0:    b = s.per[7:0];
            IDX_P1W_HI:  b = s.p1wid[15:8];
            IDX_P1W_LO:  b = s.p1wid[7:0];
            IDX_DEL_HI:  b = s.del[15:8];
            IDX_DEL_LO:  b = s.del[7:0];
            IDX_P2W_HI:  b = s.p2wid[15:8];
            IDX_P2W_LO:  b = s.p2wid[7:0];
            IDX_NUTD_HI: b = s.nut_d[15:8];
            IDX_NUTD_LO: b = s.nut_d[7:0];
            IDX_NUTW:    b = s.nut_w;
            IDX_ATT:     b = {1'b0, s.pr_att};
            IDX_FLAGS:   b = {6'b0, s.cp, s.bl};
            default:     b = 8'h00;
        endcase
        return b;
    endfunction

    // Modulo-256 sum of the 15 payload bytes; the carry is simply dropped
    function automatic logic [7:0] payload_sum(input snap_t s);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = int'(IDX_PER3); i <= int'(IDX_FLAGS); i++) begin
            acc = acc + payload_byte(s, 5'(i));
        end
        return acc;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first: start bit, d0..d7, stop bit, each CLKS_PER_BIT cycles.
// Latency: tx drops one cycle after start is accepted; ready pulses in the last stop-bit cycle.
// Backpressure: start is taken only in IDLE or alongside ready, which gives gap-free back-to-back bytes.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    tx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          bit_end;
    logic          load;

    assign bit_end = (cnt_q == LAST);
    assign load    = start && ((state_q == IDLE) || ready);
    assign tx      = tx_q;

    // State register; reset parks the line in idle-high immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: walk start -> 8 data bits -> stop, chaining straight into a new start bit if asked
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && (bit_q == 3'd7)) state_d = STOP;
            STOP:    if (bit_end) state_d = start ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bit timer, data-bit index and shift register next values
    always_comb begin
        cnt_d   = (state_q == IDLE || bit_end) ? '0 : cnt_q + CW'(1);
        bit_d   = 3'd0;
        shreg_d = shreg_q;
        if (state_q == DATA) begin
            bit_d = bit_end ? bit_q + 3'd1 : bit_q;
        end
        if (load) begin
            shreg_d = data;
        end else if (state_q == DATA && bit_end) begin
            shreg_d = {1'b0, shreg_q[7:1]};
        end
    end

    // Outputs: line level follows the state being entered so tx is a clean flop output
    always_comb begin
        ready = (state_q == STOP) && bit_end;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/param_readback_tx.sv
// Snapshots the live pulse parameters on a req rising edge and sends them as a 17-byte 8N1 frame.
// Latency: tx start bit and busy one cycle after the capturing edge; done 17*10*CLKS_PER_BIT cycles after tx falls.
// Backpressure: none; req during a frame or its done cycle is dropped, and a held req starts only one frame.
module param_readback_tx #(
    parameter int         CLKS_PER_BIT = 104,
    parameter logic [7:0] HEADER       = pulse_pkg::HEADER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [31:0] per,
    input  logic [15:0] p1wid,
    input  logic [15:0] del,
    input  logic [15:0] p2wid,
    input  logic [15:0] nut_d,
    input  logic [7:0]  nut_w,
    input  logic [6:0]  pr_att,
    input  logic        cp,
    input  logic        bl,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    import pulse_pkg::*;

    frame_state_t state_q, state_d;
    snap_t        snap_q;
    snap_t        live;
    logic [7:0]   chk_q;
    logic [4:0]   idx_q, idx_d;
    logic [4:0]   nxt_idx;
    logic         req_q;
    logic         launch_q;
    logic         go;
    logic         byte_start;
    logic [7:0]   byte_data;
    logic         byte_ready;

    assign live = {per, p1wid, del, p2wid, nut_d, nut_w, pr_att, cp, bl};

    // Only a fresh rising edge in IDLE starts a frame; the launch cycle itself also blocks new starts
    assign go = (state_q == IDLE) && !launch_q && req && !req_q;

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave IDLE on the launch cycle, finish when the checksum byte's stop bit ends
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch_q) state_d = SEND;
            SEND:    if (byte_ready && (idx_q == IDX_CHK)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and byte launch: header on the launch cycle, then the next byte whenever the serialiser frees up
    always_comb begin
        busy       = (state_q == SEND);
        done       = (state_q == DONE);
        nxt_idx    = (state_q == IDLE) ? IDX_HDR : idx_q + 5'd1;
        byte_start = ((state_q == IDLE) && launch_q) ||
                     ((state_q == SEND) && byte_ready && (idx_q != IDX_CHK));
        if (nxt_idx == IDX_HDR) begin
            byte_data = HEADER;
        end else if (nxt_idx == IDX_CHK) begin
            byte_data = chk_q;
        end else begin
            byte_data = payload_byte(snap_q, nxt_idx);
        end
        idx_d = byte_start ? nxt_idx : idx_q;
    end

    // Snapshot, checksum, byte index and request-edge tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q   <= '0;
            chk_q    <= 8'h00;
            idx_q    <= 5'd0;
            req_q    <= 1'b0;
            launch_q <= 1'b0;
        end else begin
            req_q    <= req;
            launch_q <= go;
            idx_q    <= idx_d;
            if (go) begin
                snap_q <= live;
                chk_q  <= payload_sum(live);
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk   (clk),
        .rst_n (rst_n),
        .start (byte_start),
        .data  (byte_data),
        .tx    (tx),
        .ready (byte_ready)
    );

endmodule

// File: tb/tb_param_readback_tx.sv
module tb_param_readback_tx;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 17 * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] per;
    logic [15:0] p1wid, del, p2wid, nut_d;
    logic [7:0]  nut_w;
    logic [6:0]  pr_att;
    logic        cp, bl;
    logic        tx, busy, done;

    param_readback_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid), .nut_d(nut_d),
        .nut_w(nut_w), .pr_att(pr_att), .cp(cp), .bl(bl),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] per;
        logic [15:0] p1wid, del, p2wid, nut_d;
        logic [7:0]  nut_w;
        logic [6:0]  pr_att;
        logic        cp, bl;
        logic [7:0]  chk;     // hand-computed modulo-256 payload sum
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] exp_fb [17];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         cur_g;
    bit         hold_g;
    int         req_at_g;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build(input vec_t v);
        logic [135:0] flat;
        flat = {8'hA5, v.per, v.p1wid, v.del, v.p2wid, v.nut_d, v.nut_w,
                1'b0, v.pr_att, 6'b0, v.cp, v.bl, v.chk};
        for (int i = 0; i < 17; i++) exp_fb[i] = flat[135 - 8*i -: 8];
    endtask

    task automatic set_inputs(input vec_t v);
        per = v.per; p1wid = v.p1wid; del = v.del; p2wid = v.p2wid; nut_d = v.nut_d;
        nut_w = v.nut_w; pr_att = v.pr_att; cp = v.cp; bl = v.bl;
    endtask

    task automatic set_ones();
        per = '1; p1wid = '1; del = '1; p2wid = '1; nut_d = '1;
        nut_w = '1; pr_att = '1; cp = 1'b1; bl = 1'b1;
    endtask

    task automatic advance_to(input int target);
        while (cur_g < target) begin
            @(negedge clk);
            cur_g++;
            if (!hold_g) req = (cur_g == req_at_g);
        end
    endtask

    // Pulse (or raise) req at a negedge, check the one-cycle launch latency, align cur_g=0 to the start bit.
    task automatic launch(input bit hold, output bit ok);
        int w;
        ok = 1'b0;
        req = 1'b1;
        @(negedge clk);
        if (!hold) req = 1'b0;
        check("launch_tx_idle", tx, 1'b1);
        check("launch_busy_low", busy, 1'b0);
        w = 0;
        while (!ok && w < 20) begin
            @(negedge clk);
            w++;
            if (tx === 1'b0) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL start_timeout: tx never fell, got 1 expected 0");
        end else begin
            check("start_latency", w, 1);
            check("busy_at_start", busy, 1'b1);
        end
        cur_g = 0;
    endtask

    task automatic run_frame(input vec_t v, input bit scramble, input bit hold, input int req_at);
        logic [9:0] sh;
        int         dbefore;
        bit         ok;
        build(v);
        set_inputs(v);
        hold_g   = hold;
        req_at_g = req_at;
        dbefore  = done_cnt;
        req = 1'b1;
        if (scramble) begin
            @(negedge clk);
            req = 1'b0;
            set_ones();
            check("launch_tx_idle", tx, 1'b1);
            check("launch_busy_low", busy, 1'b0);
            ok = 1'b0;
            for (int w = 0; w < 20 && !ok; w++) begin
                @(negedge clk);
                if (tx === 1'b0) ok = 1'b1;
            end
            if (!ok) begin
                checks++; errors++;
                $display("FAIL start_timeout: tx never fell, got 1 expected 0");
            end
            cur_g = 0;
        end else begin
            launch(hold, ok);
        end
        if (!ok) return;
        for (int b = 0; b < 17; b++) begin
            for (int j = 0; j < 10; j++) begin
                advance_to(CPB * (b * 10 + j) + CPB / 2);
                sh[j] = tx;
            end
            check($sformatf("frame_byte%0d", b), sh, {1'b1, exp_fb[b], 1'b0});
        end
        advance_to(FRAME_CYC - 1);
        check("done_early", done, 1'b0);
        check("busy_last_stop", busy, 1'b1);
        advance_to(FRAME_CYC);
        check("done_pulse", done, 1'b1);
        check("busy_in_done", busy, 1'b0);
        check("tx_idle_in_done", tx, 1'b1);
        advance_to(FRAME_CYC + 1);
        check("done_one_cycle", done, 1'b0);
        check("done_count", done_cnt - dbefore, 1);
    endtask

    initial begin
        bit ok;
        bit quiet;
        int dsave;

        vecs[0] = '{per:32'h0000_1F40, p1wid:16'h0010, del:16'h0064, p2wid:16'h0020,
                    nut_d:16'h0000, nut_w:8'h05, pr_att:7'h1A, cp:1'b1, bl:1'b0, chk:8'h14};
        vecs[1] = '{per:32'hFFFF_FFFF, p1wid:16'hFFFF, del:16'hFFFF, p2wid:16'hFFFF,
                    nut_d:16'hFFFF, nut_w:8'hFF, pr_att:7'h7F, cp:1'b1, bl:1'b1, chk:8'h75};
        vecs[2] = '{per:32'h1234_5678, p1wid:16'h0102, del:16'h0304, p2wid:16'h0506,
                    nut_d:16'h0708, nut_w:8'h09, pr_att:7'h0A, cp:1'b0, bl:1'b1, chk:8'h4C};
        vecs[3] = '{per:32'h8080_8080, p1wid:16'h8080, del:16'h8080, p2wid:16'h8080,
                    nut_d:16'h8080, nut_w:8'h80, pr_att:7'h40, cp:1'b1, bl:1'b1, chk:8'hC3};

        rst_n = 1'b0; req = 1'b0; hold_g = 1'b0; req_at_g = -1; cur_g = 0;
        set_inputs(vecs[0]);
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table: each vector framed once; the first also scrambles inputs right after capture
        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i], i == 0, 1'b0, -1);
            repeat (3) @(negedge clk);
        end

        // Second req 100 cycles into a frame is dropped and not queued
        run_frame(vecs[2], 1'b0, 1'b0, 100);
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        check("no_queued_frame", quiet, 1'b1);
        run_frame(vecs[3], 1'b0, 1'b0, -1);
        repeat (3) @(negedge clk);

        // Reset during byte 7, data bit 3: line idles at once, no done, clean frame afterwards
        build(vecs[0]);
        set_inputs(vecs[0]);
        hold_g = 1'b0; req_at_g = -1;
        dsave = done_cnt;
        launch(1'b0, ok);
        if (ok) begin
            advance_to(CPB * (7 * 10 + 4) + 1);
            check("pre_reset_tx", tx, exp_fb[7][3]);
            #1 rst_n = 1'b0;
            #1;
            check("reset_tx_async", tx, 1'b1);
            check("reset_busy_async", busy, 1'b0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (FRAME_CYC) @(negedge clk);
            check("no_done_after_abort", done_cnt - dsave, 0);
            run_frame(vecs[0], 1'b0, 1'b0, -1);
        end
        repeat (3) @(negedge clk);

        // req held high for ~2000 cycles: exactly one frame and no restart
        dsave = done_cnt;
        run_frame(vecs[1], 1'b0, 1'b1, -1);
        quiet = 1'b1;
        repeat (2000 - FRAME_CYC) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        check("held_req_no_restart", quiet, 1'b1);
        check("held_req_one_done", done_cnt - dsave, 1);
        req = 1'b0;
        @(negedge clk);
        run_frame(vecs[3], 1'b0, 1'b0, -1);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
